// File: rtl/core_pkg.sv
// Shared encodings and types for the core's pipeline control logic.
package core_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Destination info for one in-flight instruction past E.
  typedef struct packed {
    reg_addr_t  waddr;
    logic       reg_wr;
    logic [1:0] wb_sel;
  } stage_info_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select comparator for one execute-stage operand; M beats W, x0 never forwards.
module hazard_fwd_sel
  import core_pkg::*;
(
  input  reg_addr_t  rs_i,
  input  reg_addr_t  waddr_m_i,
  input  logic       reg_wr_m_i,
  input  reg_addr_t  waddr_w_i,
  input  logic       reg_wr_w_i,
  output logic [1:0] sel_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives sel_o and no latch is inferred.
    sel_o = FWD_RF;
    if (reg_wr_m_i && (waddr_m_i != '0) && (waddr_m_i == rs_i)) begin
      sel_o = FWD_M;
    end else if (reg_wr_w_i && (waddr_w_i != '0) && (waddr_w_i == rs_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: M/W shadow pipeline, forwarding selects,
// load-use stall, branch flush and stall/flush event counters.
module hazard_unit
  import core_pkg::*;
#(
  parameter logic [1:0] WB_LOAD = WB_SEL_LOAD,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       raddr1D,
  input  logic [4:0]       raddr2D,
  input  logic [4:0]       raddr1E,
  input  logic [4:0]       raddr2E,
  input  logic [4:0]       waddrE,
  input  logic             reg_wrE,
  input  logic [1:0]       wb_selE,
  input  logic             br_takenE,
  output logic [1:0]       forward_AE,
  output logic [1:0]       forward_BE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_info_t      m_q;
  reg_addr_t        waddr_w_q;
  logic             reg_wr_w_q;
  logic             bubble_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic effe_wr;
  logic effe_load;
  logic lwstall;

  // A flushed ID/EX register still carries stale fields, so mask them here.
  assign effe_wr   = reg_wrE & ~bubble_q;
  assign effe_load = effe_wr & (wb_selE == WB_LOAD);
  assign lwstall   = effe_load & (waddrE != '0) &
                     ((waddrE == raddr1D) | (waddrE == raddr2D));

  // A taken branch squashes the stalled decode instruction, so it overrides the stall.
  assign StallF = lwstall & ~br_takenE;
  assign StallD = lwstall & ~br_takenE;
  assign FlushD = br_takenE;
  assign FlushE = lwstall | br_takenE;

  hazard_fwd_sel u_fwd_a (
    .rs_i       (raddr1E),
    .waddr_m_i  (m_q.waddr),
    .reg_wr_m_i (m_q.reg_wr),
    .waddr_w_i  (waddr_w_q),
    .reg_wr_w_i (reg_wr_w_q),
    .sel_o      (forward_AE)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_i       (raddr2E),
    .waddr_m_i  (m_q.waddr),
    .reg_wr_m_i (m_q.reg_wr),
    .waddr_w_i  (waddr_w_q),
    .reg_wr_w_i (reg_wr_w_q),
    .sel_o      (forward_BE)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q         <= '0;
      waddr_w_q   <= '0;
      reg_wr_w_q  <= 1'b0;
      bubble_q    <= 1'b1;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so W captures the old M value in the same edge M updates.
      m_q         <= '{waddr: waddrE, reg_wr: effe_wr, wb_sel: wb_selE};
      waddr_w_q   <= m_q.waddr;
      reg_wr_w_q  <= m_q.reg_wr;
      bubble_q    <= FlushE;
      if (StallF)    stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_takenE) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // wb_sel in M is kept for visibility of the load in flight; nothing consumes it yet.
  logic unused_wb_sel_m;
  assign unused_wb_sel_m = ^m_q.wb_sel;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios then random traffic,
// compared against an in-flight instruction list model.
module tb_hazard_unit;
  import core_pkg::*;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [4:0]       raddr1D, raddr2D, raddr1E, raddr2E, waddrE;
  logic             reg_wrE, br_takenE;
  logic [1:0]       wb_selE;
  logic [1:0]       forward_AE, forward_BE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  hazard_unit #(.WB_LOAD(2'b10), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .raddr1D    (raddr1D),
    .raddr2D    (raddr2D),
    .raddr1E    (raddr1E),
    .raddr2E    (raddr2E),
    .waddrE     (waddrE),
    .reg_wrE    (reg_wrE),
    .wb_selE    (wb_selE),
    .br_takenE  (br_takenE),
    .forward_AE (forward_AE),
    .forward_BE (forward_BE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instructions that have left E, youngest first ([0] in M, [1] in W).
  typedef struct {
    logic [4:0] rd;
    bit         wr;
  } older_t;

  older_t      older[$];
  bit          m_bubble;
  int unsigned m_stalls;
  int unsigned m_flushes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    older.delete();
    older.push_back('{rd: 5'd0, wr: 1'b0});
    older.push_back('{rd: 5'd0, wr: 1'b0});
    m_bubble  = 1'b1;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  function automatic bit exp_eff_wr();
    return reg_wrE && !m_bubble;
  endfunction

  function automatic bit exp_lwstall();
    return exp_eff_wr() && (wb_selE == 2'b10) && (waddrE != 5'd0) &&
           ((waddrE == raddr1D) || (waddrE == raddr2D));
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    foreach (older[i]) begin
      if (older[i].wr && older[i].rd == rs) return (i == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic drive(input logic [4:0] r1d, input logic [4:0] r2d,
                       input logic [4:0] r1e, input logic [4:0] r2e,
                       input logic [4:0] we, input logic wr,
                       input logic [1:0] sel, input logic br);
    raddr1D = r1d; raddr2D = r2d; raddr1E = r1e; raddr2E = r2e;
    waddrE = we; reg_wrE = wr; wb_selE = sel; br_takenE = br;
  endtask

  // Compare every output against the model at the falling edge.
  task automatic settle();
    bit lw, br;
    @(negedge clk);
    lw = exp_lwstall();
    br = br_takenE;
    check("fwd_a",  {30'd0, forward_AE}, {30'd0, exp_fwd(raddr1E)});
    check("fwd_b",  {30'd0, forward_BE}, {30'd0, exp_fwd(raddr2E)});
    check("stallf", {31'd0, StallF}, {31'd0, lw && !br});
    check("stalld", {31'd0, StallD}, {31'd0, lw && !br});
    check("flushd", {31'd0, FlushD}, {31'd0, br});
    check("flushe", {31'd0, FlushE}, {31'd0, lw || br});
    check("stall_cnt", stall_cnt, m_stalls);
    check("flush_cnt", flush_cnt, m_flushes);
  endtask

  task automatic advance();
    bit lw, br;
    @(posedge clk);
    lw = exp_lwstall();
    br = br_takenE;
    if (lw && !br) m_stalls++;
    if (br) m_flushes++;
    older.push_front('{rd: waddrE, wr: exp_eff_wr()});
    void'(older.pop_back());
    m_bubble = lw || br;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fwd_a"}, {30'd0, forward_AE}, 32'd0);
    check({tag, "_fwd_b"}, {30'd0, forward_BE}, 32'd0);
    check({tag, "_ctl"}, {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    check({tag, "_flush_cnt"}, flush_cnt, 32'd0);
  endtask

  initial begin
    int unsigned st0, fl0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    model_reset();
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // First cycle after reset: bubble still set.
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    settle(); advance();

    // ALU-ALU: add x5, consumer next cycle from M, later from W.
    drive(0, 0, 0, 0, 5, 1, 2'b00, 0);
    settle(); advance();
    drive(0, 0, 5, 0, 6, 1, 2'b00, 0);
    settle(); check("tp1_fwd_m", {30'd0, forward_AE}, 32'd2); advance();
    drive(0, 0, 5, 0, 0, 0, 2'b00, 0);
    settle(); check("tp1_fwd_w", {30'd0, forward_AE}, 32'd1); advance();

    // Load-use: load x7 with raddr2D=7.
    st0 = m_stalls;
    drive(0, 7, 0, 0, 7, 1, 2'b10, 0);
    settle();
    check("tp2_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
    check("tp2_flushd", {31'd0, FlushD}, 32'd0);
    advance();
    drive(0, 7, 1, 2, 7, 1, 2'b10, 0);
    settle();
    check("tp2_one_cycle", {31'd0, StallF}, 32'd0);
    check("tp2_cnt", stall_cnt, st0 + 1);
    advance();
    drive(0, 0, 0, 7, 8, 1, 2'b00, 0);
    settle(); check("tp2_fwd_b_w", {30'd0, forward_BE}, 32'd1); advance();

    // Bubble masking after a flush.
    drive(0, 0, 0, 0, 0, 0, 2'b00, 1);
    settle(); check("tp3_flush", {30'd0, FlushD, FlushE}, 32'd3); advance();
    drive(19, 0, 0, 0, 19, 1, 2'b10, 0);
    settle(); check("tp3_no_stall", {30'd0, StallF, FlushE}, 32'd0); advance();
    drive(0, 0, 19, 19, 0, 0, 2'b00, 0);
    settle(); check("tp3_fwd_m", {30'd0, forward_AE}, 32'd0); advance();
    drive(0, 0, 19, 19, 0, 0, 2'b00, 0);
    settle(); check("tp3_fwd_w", {30'd0, forward_BE}, 32'd0); advance();

    // Branch and load-use together: branch wins.
    st0 = m_stalls;
    fl0 = m_flushes;
    drive(4, 0, 0, 0, 4, 1, 2'b10, 1);
    settle();
    check("tp4_ctl", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd3);
    advance();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    settle();
    check("tp4_stall_cnt", stall_cnt, st0);
    check("tp4_flush_cnt", flush_cnt, fl0 + 1);
    advance();

    // Priority of M over W, and x0 never forwards.
    drive(0, 0, 0, 0, 3, 1, 2'b00, 0);
    settle(); advance();
    drive(0, 0, 0, 0, 3, 1, 2'b00, 0);
    settle(); advance();
    drive(0, 0, 3, 0, 0, 1, 2'b00, 0);
    settle(); check("tp5_prio", {30'd0, forward_AE}, 32'd2); advance();
    drive(0, 0, 0, 0, 3, 1, 2'b00, 0);
    settle(); check("tp5_x0", {28'd0, forward_AE, forward_BE}, 32'd0); advance();

    // Async reset between edges, with inputs that would otherwise forward and stall.
    drive(3, 0, 3, 3, 3, 1, 2'b10, 0);
    rst = 1'b0;
    #1;
    check_all_zero("tp6_async");
    @(posedge clk);
    #2;
    check_all_zero("tp6_held");
    rst = 1'b1;
    model_reset();
    drive(9, 0, 0, 0, 9, 1, 2'b10, 0);
    settle(); check("tp6_bubble", {30'd0, StallF, FlushE}, 32'd0); advance();

    // Random traffic on a narrow register range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage core. It consumes the execute-stage fields produced by the ID/EX register, plus decode-stage source addresses and the execute-stage branch decision.
- It drives StallF, StallD, FlushD and FlushE back into the IF/ID and ID/EX registers, and the forwarding selects into the execute-stage operand muxes.
- Internally it keeps a shadow pipeline of destination info for the M and W stages, a bubble tracker, and event counters.

Parameters:
- WB_LOAD, 2'b10, wb_sel encoding that marks a load (result arrives from data memory).
- CNT_W, 32, width of the stall and flush event counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- raddr1D  in  5  decode-stage rs1
- raddr2D  in  5  decode-stage rs2
- raddr1E  in  5  execute-stage rs1
- raddr2E  in  5  execute-stage rs2
- waddrE  in  5  execute-stage rd
- reg_wrE  in  1  execute-stage register-write enable
- wb_selE  in  2  execute-stage writeback select
- br_takenE  in  1  branch/jump taken, resolved in E
- forward_AE  out  2  operand A select: 00 register file, 01 W result, 10 M ALU result
- forward_BE  out  2  operand B select, same encoding as forward_AE
- StallF  out  1  hold the PC
- StallD  out  1  hold the IF/ID register
- FlushD  out  1  squash the IF/ID register
- FlushE  out  1  squash the ID/EX register
- stall_cnt  out  CNT_W  load-use stall cycles since reset
- flush_cnt  out  CNT_W  branch flush events since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - waddrM, reg_wrM, wb_selM, waddrW, reg_wrW all 0.
  - bubbleE=1.
  - Both counters 0.
  - All combinational outputs are therefore 0 during reset.
- Bubble tracking:
  - bubbleE <= FlushE each clk.
  - The ID/EX flush value is not a clean NOP, so when bubbleE=1 the E inputs are treated as reg_wr=0 and wb_sel=0.
  - Effective signals: effE_wr = reg_wrE & ~bubbleE; effE_load = effE_wr & (wb_selE==WB_LOAD).
- Shadow pipeline, advances every clk (no M/W stall exists):
  - M <= {waddrE, effE_wr, wb_selE}
  - W <= M
- Forwarding, combinational. For each operand X in {A,B} with source rsE:
  - If reg_wrM & waddrM!=0 & waddrM==rsE: select 10 (M has priority).
  - Else if reg_wrW & waddrW!=0 & waddrW==rsE: select 01.
  - Else: select 00.
  - rsE==0 always gives 00.
- Load-use hazard, combinational:
  - lwstall = effE_load & waddrE!=0 & (waddrE==raddr1D | waddrE==raddr2D).
  - lwstall drives StallF=1, StallD=1, FlushE=1 (bubble inserted, load advances to M).
  - The following cycle forwards the load data from W via select 01.
- Branch, combinational:
  - br_takenE=1 drives FlushD=1 and FlushE=1.
- Simultaneous lwstall and br_takenE:
  - The branch wins: StallF=0, StallD=0, FlushD=1, FlushE=1.
  - The stall is suppressed because the decode instruction is squashed.
- Latency:
  - Stall and flush outputs are same-cycle combinational.
  - Shadow state lags E by one cycle (M) and two cycles (W).
- Counters:
  - stall_cnt increments on each cycle with an effective stall (lwstall & ~br_takenE).
  - flush_cnt increments on each cycle with br_takenE.
  - Both wrap modulo 2^CNT_W.
- Reset asserted mid-operation: all registered state clears immediately, and bubbleE=1 holds until the first clk edge after release.

Decomposition:
- core_pkg holds:
  - the WB_LOAD / wb_sel encodings
  - the forwarding select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - the 5-bit register-address type
- One sub-module, hazard_fwd_sel: the combinational forward-select comparator. It is instantiated twice, once for operand A and once for operand B.
- Shadow pipeline, bubble tracker and counters stay in hazard_unit.

Test Plan:
1. ALU-ALU back-to-back: E = add x5 (reg_wrE=1, waddrE=5, wb_sel=ALU); next cycle raddr1E=5 → forward_AE=10. Two cycles later, with an unrelated instruction in between → forward_AE=01.
2. Load-use: E = load x7 (wb_selE=2'b10), raddr2D=7 → StallF=StallD=FlushE=1 for exactly one cycle, stall_cnt +1. Next cycle raddr2E=7 → forward_BE=01 (after load in M/W timing).
3. Bubble masking: assert the flush path, then drive reg_wrE=1, waddrE=19 in the following cycle with raddr1D=19 → no lwstall. A later consumer with rs=19 sees forward=00.
4. Branch vs load-use collision: br_takenE=1 with a load-use match → FlushD=1, FlushE=1, StallF=StallD=0, flush_cnt +1, stall_cnt unchanged.
5. x0 and priority: waddrM=waddrW=3, raddr1E=3 → forward_AE=10. With waddrM=0 and raddr1E=0 → 00.
6. Async reset mid-stream: drop rst between clk edges → outputs, shadow state and counters go to 0 immediately. After release, the first E inputs are ignored for one cycle (bubbleE=1).
